// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU-B select sequencer: FSM states, mux selects,
// ALU op codes and the instruction fields the decoder recognises.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    DONE
  } state_e;

  // ALU-B mux sources; codes 6 and 7 are never driven
  localparam logic [2:0] ULAB_REG_B    = 3'd0;
  localparam logic [2:0] ULAB_CONST4   = 3'd1;
  localparam logic [2:0] ULAB_SEXT     = 3'd2;
  localparam logic [2:0] ULAB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] ULAB_ZEXT     = 3'd4;
  localparam logic [2:0] ULAB_CONST1   = 3'd5;

  localparam logic [2:0] ULA_PASS_A = 3'b000;
  localparam logic [2:0] ULA_ADD    = 3'b001;
  localparam logic [2:0] ULA_SUB    = 3'b010;
  localparam logic [2:0] ULA_AND    = 3'b011;
  localparam logic [2:0] ULA_CMP    = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] op;
    logic       is_mem;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/ula_b_dec.sv
// Combinational EXEC-phase decoder: {opcode, funct} -> ALU-B select, ALU op,
// memory-access flag and illegal flag. Illegal encodings yield sel=0, op=pass A.
module ula_b_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec_o = '{sel: ULAB_REG_B, op: ULA_PASS_A, is_mem: 1'b0, is_illegal: 1'b0};
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  dec_o.op = ULA_ADD;
          FN_SUB:  dec_o.op = ULA_SUB;
          FN_AND:  dec_o.op = ULA_AND;
          FN_SLT:  dec_o.op = ULA_CMP;
          default: dec_o.is_illegal = 1'b1;
        endcase
      end
      OP_ADDI: dec_o = '{sel: ULAB_SEXT, op: ULA_ADD, is_mem: 1'b0, is_illegal: 1'b0};
      OP_SLTI: dec_o = '{sel: ULAB_SEXT, op: ULA_CMP, is_mem: 1'b0, is_illegal: 1'b0};
      OP_ANDI: dec_o = '{sel: ULAB_ZEXT, op: ULA_AND, is_mem: 1'b0, is_illegal: 1'b0};
      OP_BEQ,
      OP_BNE:  dec_o = '{sel: ULAB_REG_B, op: ULA_SUB, is_mem: 1'b0, is_illegal: 1'b0};
      OP_LW,
      OP_SW:   dec_o = '{sel: ULAB_SEXT, op: ULA_ADD, is_mem: 1'b1, is_illegal: 1'b0};
      default: dec_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ula_b_sel_seq.sv
// Multicycle sequencer driving the ALU-B mux select and ALU op for one instruction:
// FETCH -> DECODE -> EXEC [-> MEM] -> DONE, with registered (Moore) outputs.
module ula_b_sel_seq
  import ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MEM_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_wait,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [2:0]       sel_ulaB,
  output logic [2:0]       ula_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] DWELL_INIT = 3'(MEM_CYCLES - 1);

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic [2:0]       dwell_q, dwell_d;
  logic [2:0]       sel_q, sel_d, op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [5:0]       dec_opcode, dec_funct;
  dec_t             dec;

  // Leaving DECODE the decoder must see the live fields so EXEC outputs land with the state.
  assign dec_opcode = (state_q == DECODE) ? opcode : opcode_q;
  assign dec_funct  = (state_q == DECODE) ? funct  : funct_q;

  ula_b_dec u_dec (
    .opcode_i (dec_opcode),
    .funct_i  (dec_funct),
    .dec_o    (dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      funct_q   <= '0;
      dwell_q   <= '0;
      sel_q     <= ULAB_REG_B;
      op_q      <= ULA_PASS_A;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      sel_q     <= sel_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      if (state_q == DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  if (!mem_wait) state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (dec.is_illegal) begin
          state_d = IDLE;
        end else if (dec.is_mem) begin
          state_d = MEM;
          dwell_d = DWELL_INIT;
        end else begin
          state_d = DONE;
        end
      end
      // Dwell counts only unstalled cycles; exit needs both the count spent and no stall.
      MEM: begin
        if (!mem_wait) begin
          if (dwell_q == 3'd0) state_d = DONE;
          else                 dwell_d = dwell_q - 3'd1;
        end
      end
      DONE:    state_d = start ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values are computed from the next state so they appear together with it.
  always_comb begin
    sel_d     = ULAB_REG_B;
    op_d      = ULA_PASS_A;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    illegal_d = 1'b0;
    retired_d = retired_q;
    case (state_d)
      FETCH: begin
        sel_d = ULAB_CONST4;
        op_d  = ULA_ADD;
      end
      DECODE: begin
        sel_d = ULAB_SEXT_SH2;
        op_d  = ULA_ADD;
      end
      EXEC: begin
        sel_d     = dec.sel;
        op_d      = dec.op;
        illegal_d = dec.is_illegal;
      end
      MEM: begin
        sel_d = sel_q;
        op_d  = op_q;
      end
      DONE:    retired_d = retired_q + CNT_W'(1);
      default: ;
    endcase
  end

  assign sel_ulaB = sel_q;
  assign ula_op   = op_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_ula_b_sel_seq.sv
// Self-checking bench for ula_b_sel_seq: table-driven vectors, directed corner
// sequences and randomized instructions against a per-cycle trace model.
`timescale 1ns/1ps
module tb_ula_b_sel_seq;

  localparam int CNT_W      = 4;
  localparam int MEM_CYCLES = 1;

  logic             clk = 1'b0;
  logic             reset, start, mem_wait;
  logic [5:0]       opcode, funct;
  logic [2:0]       sel_ulaB, ula_op;
  logic             busy, done, illegal;
  logic [CNT_W-1:0] retired;

  int total   = 0;
  int bad     = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  ula_b_sel_seq #(.CNT_W(CNT_W), .MEM_CYCLES(MEM_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mem_wait (mem_wait),
    .opcode   (opcode),
    .funct    (funct),
    .sel_ulaB (sel_ulaB),
    .ula_op   (ula_op),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .retired  (retired)
  );

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] sel;
    logic [2:0] uop;
    bit         mem;
    bit         ill;
  } vec_t;

  // One expected cycle of an instruction plus the inputs driven during it
  typedef struct {
    bit         chk_so;
    logic [2:0] sel;
    logic [2:0] op;
    bit         dn;
    bit         ill;
    int         ret;
    bit         mw;
    bit         st;
    string      ph;
  } cyc_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  // Reference classification of an instruction from the opcode/funct tables
  function automatic vec_t ref_cls(input logic [5:0] op, input logic [5:0] fn);
    vec_t c;
    c = '{op, fn, 3'd0, 3'd0, 1'b0, 1'b1};
    case (op)
      6'h00: case (fn)
        6'h20:   c = '{op, fn, 3'd0, 3'b001, 1'b0, 1'b0};
        6'h22:   c = '{op, fn, 3'd0, 3'b010, 1'b0, 1'b0};
        6'h24:   c = '{op, fn, 3'd0, 3'b011, 1'b0, 1'b0};
        6'h2A:   c = '{op, fn, 3'd0, 3'b111, 1'b0, 1'b0};
        default: ;
      endcase
      6'h08:        c = '{op, fn, 3'd2, 3'b001, 1'b0, 1'b0};
      6'h0A:        c = '{op, fn, 3'd2, 3'b111, 1'b0, 1'b0};
      6'h0C:        c = '{op, fn, 3'd4, 3'b011, 1'b0, 1'b0};
      6'h04, 6'h05: c = '{op, fn, 3'd0, 3'b010, 1'b0, 1'b0};
      6'h23, 6'h2B: c = '{op, fn, 3'd2, 3'b001, 1'b1, 1'b0};
      default: ;
    endcase
    return c;
  endfunction

  // Precondition: at a negedge with the DUT in IDLE or DONE. sf/sm = stall cycles
  // in FETCH/MEM; chain keeps start high in DONE for a back-to-back instruction.
  task automatic run_instr(input string tag, input vec_t v, input int sf, input int sm,
                           input bit mix, input bit chain);
    cyc_t q[$];
    int   ones, zeros;
    bit   w;
    for (int i = 0; i <= sf; i++)
      q.push_back('{1'b1, 3'd1, 3'b001, 1'b0, 1'b0, exp_ret, (i < sf), rb(), "fetch"});
    q.push_back('{1'b1, 3'd3, 3'b001, 1'b0, 1'b0, exp_ret, rb(), rb(), "decode"});
    q.push_back('{1'b1, v.sel, v.uop, 1'b0, v.ill, exp_ret, rb(), rb(), "exec"});
    if (v.mem && !v.ill) begin
      ones  = sm;
      zeros = MEM_CYCLES;
      while (ones + zeros > 0) begin
        w = (ones > 0) && ((zeros == 1) || !mix || rb());
        if (w) ones--; else zeros--;
        q.push_back('{1'b1, v.sel, v.uop, 1'b0, 1'b0, exp_ret, w, rb(), "mem"});
      end
    end
    if (!v.ill) begin
      exp_ret = (exp_ret + 1) % (1 << CNT_W);
      q.push_back('{1'b0, 3'd0, 3'd0, 1'b1, 1'b0, exp_ret, rb(), chain, "done"});
    end

    start    = 1'b1;
    opcode   = v.op;
    funct    = v.fn;
    mem_wait = rb();
    foreach (q[i]) begin
      @(negedge clk);
      check($sformatf("%s[%0d] %s busy", tag, i, q[i].ph), 32'(busy), 32'd1);
      check($sformatf("%s[%0d] %s done", tag, i, q[i].ph), 32'(done), 32'(q[i].dn));
      check($sformatf("%s[%0d] %s illegal", tag, i, q[i].ph), 32'(illegal), 32'(q[i].ill));
      check($sformatf("%s[%0d] %s retired", tag, i, q[i].ph), 32'(retired), 32'(q[i].ret));
      if (q[i].chk_so) begin
        check($sformatf("%s[%0d] %s sel", tag, i, q[i].ph), 32'(sel_ulaB), 32'(q[i].sel));
        check($sformatf("%s[%0d] %s ula_op", tag, i, q[i].ph), 32'(ula_op), 32'(q[i].op));
      end
      mem_wait = q[i].mw;
      start    = q[i].st;
    end
    if (v.ill || !chain) begin
      @(negedge clk);
      check($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
      check($sformatf("%s idle done", tag), 32'(done), 32'd0);
      check($sformatf("%s idle illegal", tag), 32'(illegal), 32'd0);
      check($sformatf("%s idle retired", tag), 32'(retired), 32'(exp_ret));
      start = 1'b0;
    end
  endtask

  vec_t       vt[13];
  vec_t       v;
  logic [5:0] op_pool[10];
  logic [5:0] fn_pool[4];

  initial begin
    vt[0]  = '{6'h00, 6'h20, 3'd0, 3'b001, 1'b0, 1'b0};
    vt[1]  = '{6'h00, 6'h22, 3'd0, 3'b010, 1'b0, 1'b0};
    vt[2]  = '{6'h00, 6'h24, 3'd0, 3'b011, 1'b0, 1'b0};
    vt[3]  = '{6'h00, 6'h2A, 3'd0, 3'b111, 1'b0, 1'b0};
    vt[4]  = '{6'h00, 6'h21, 3'd0, 3'b000, 1'b0, 1'b1};
    vt[5]  = '{6'h08, 6'h15, 3'd2, 3'b001, 1'b0, 1'b0};
    vt[6]  = '{6'h0A, 6'h00, 3'd2, 3'b111, 1'b0, 1'b0};
    vt[7]  = '{6'h0C, 6'h3F, 3'd4, 3'b011, 1'b0, 1'b0};
    vt[8]  = '{6'h04, 6'h00, 3'd0, 3'b010, 1'b0, 1'b0};
    vt[9]  = '{6'h05, 6'h22, 3'd0, 3'b010, 1'b0, 1'b0};
    vt[10] = '{6'h23, 6'h01, 3'd2, 3'b001, 1'b1, 1'b0};
    vt[11] = '{6'h2B, 6'h00, 3'd2, 3'b001, 1'b1, 1'b0};
    vt[12] = '{6'h3F, 6'h20, 3'd0, 3'b000, 1'b0, 1'b1};
    op_pool = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h2A};

    reset    = 1'b0;
    start    = 1'b0;
    mem_wait = 1'b0;
    opcode   = '0;
    funct    = '0;
    #12;
    check("reset sel", 32'(sel_ulaB), 32'd0);
    check("reset ula_op", 32'(ula_op), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle after reset busy", 32'(busy), 32'd0);

    // Table-driven single instructions, no stalls
    for (int i = 0; i < 13; i++)
      run_instr($sformatf("vec%0d", i), vt[i], 0, 0, 1'b0, 1'b0);

    // lw with a 3-cycle MEM stall, then a FETCH stall on addi
    run_instr("lw_stall", vt[10], 0, 3, 1'b0, 1'b0);
    run_instr("addi_fstall", vt[5], 2, 0, 1'b0, 1'b0);

    // Back-to-back beq: start held through DONE, busy never drops
    run_instr("beq_b2b_a", vt[8], 0, 0, 1'b0, 1'b1);
    run_instr("beq_b2b_b", vt[8], 0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-DECODE
    start  = 1'b1;
    opcode = 6'h23;
    funct  = 6'h00;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst fetch sel", 32'(sel_ulaB), 32'd1);
    @(negedge clk);
    check("pre_rst decode sel", 32'(sel_ulaB), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("async_rst sel", 32'(sel_ulaB), 32'd0);
    check("async_rst ula_op", 32'(ula_op), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst illegal", 32'(illegal), 32'd0);
    check("async_rst retired", 32'(retired), 32'd0);
    exp_ret = 0;
    @(negedge clk);
    reset = 1'b1;
    run_instr("post_rst", vt[0], 0, 0, 1'b0, 1'b0);

    // 16 andi instructions wrap the 4-bit counter through 15 -> 0
    for (int i = 0; i < 16; i++)
      run_instr($sformatf("andi_wrap%0d", i), vt[7], 0, 0, 1'b0, 1'b0);
    check("wrap final retired", 32'(retired), 32'd1);

    // Randomized instructions, stalls and chaining against the model
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(7, 0) == 0) ? 6'($urandom) : op_pool[$urandom_range(9, 0)];
      fn = ($urandom_range(4, 0) == 0) ? 6'($urandom) : fn_pool[$urandom_range(3, 0)];
      v  = ref_cls(op, fn);
      run_instr($sformatf("rnd%0d", i), v, $urandom_range(3, 0), $urandom_range(3, 0),
                1'b1, (i < 79) ? rb() : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
